// File: rtl/sauria_pkg.sv
// Shared SAURIA array defaults and the weight-row type used by the weight feeder.
package sauria_pkg;
  localparam int X                  = 16;
  localparam int IB_W               = 8;
  localparam int WEI_FIFO_POSITIONS = 4;

  typedef logic [X-1:0][IB_W-1:0] wei_row_t;
endpackage

// File: rtl/wei_row_fifo.sv
// Row-wide weight FIFO: push when not full, pop on request when not empty.
module wei_row_fifo #(
  parameter int W     = 128,
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH+1)
) (
  input  logic          i_clk,
  input  logic          i_rstn,
  input  logic          i_clear,
  input  logic [W-1:0]  i_wdata,
  input  logic          i_push_req,
  output logic          o_ready,
  input  logic          i_pop_req,
  output logic [W-1:0]  o_rdata,
  output logic [CW-1:0] o_count,
  output logic          o_empty,
  output logic          o_full
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  r_mem [DEPTH];
  logic [PW-1:0] r_wptr, r_rptr;
  logic [CW-1:0] r_count;
  logic          w_push, w_pop;

  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == CW'(DEPTH));
  assign o_ready = !o_full;
  assign o_count = r_count;
  assign o_rdata = r_mem[r_rptr];

  // Full refuses a push even when a pop frees a slot on the same edge.
  assign w_push = i_push_req && !o_full;
  assign w_pop  = i_pop_req && !o_empty;

  always_ff @(posedge i_clk) begin
    if (w_push && !i_clear) r_mem[r_wptr] <= i_wdata;
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (i_clear) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= (r_wptr == PW'(DEPTH-1)) ? '0 : r_wptr + 1'b1;
      if (w_pop)  r_rptr <= (r_rptr == PW'(DEPTH-1)) ? '0 : r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end
endmodule

// File: rtl/wei_skew_feeder.sv
// Weight feeder: row FIFO followed by a skew triangle (column c delayed c+1 advances).
// Optional macro WEI_FEEDER_ZERO_DET_EN adds registered per-column zero flags o_zero.
module wei_skew_feeder
  import sauria_pkg::*;
#(
  parameter int X     = sauria_pkg::X,
  parameter int IB_W  = sauria_pkg::IB_W,
  parameter int DEPTH = sauria_pkg::WEI_FIFO_POSITIONS
) (
  input  logic                       i_clk,
  input  logic                       i_rstn,
  input  logic                       i_clear,
  input  logic [X*IB_W-1:0]          i_sram_data,
  input  logic                       i_sram_valid,
  output logic                       o_sram_ready,
  input  logic                       i_advance,
  output logic [X*IB_W-1:0]          o_wei_data,
  output logic [X-1:0]               o_col_valid,
`ifdef WEI_FEEDER_ZERO_DET_EN
  output logic [X-1:0]               o_zero,
`endif
  output logic [$clog2(DEPTH+1)-1:0] o_count,
  output logic                       o_empty,
  output logic                       o_full
);
  logic [X-1:0][IB_W-1:0] w_head;
  logic [X-1:0][IB_W-1:0] w_in_d;
  logic                   w_in_v;

  wei_row_fifo #(.W(X*IB_W), .DEPTH(DEPTH)) u_fifo (
    .i_clk      (i_clk),
    .i_rstn     (i_rstn),
    .i_clear    (i_clear),
    .i_wdata    (i_sram_data),
    .i_push_req (i_sram_valid),
    .o_ready    (o_sram_ready),
    .i_pop_req  (i_advance),
    .o_rdata    (w_head),
    .o_count    (o_count),
    .o_empty    (o_empty),
    .o_full     (o_full)
  );

  // An empty FIFO injects a bubble; the storage head is stale then.
  assign w_in_v = !o_empty;
  assign w_in_d = o_empty ? '0 : w_head;

  for (genvar c = 0; c < X; c++) begin : g_col
    logic [IB_W-1:0] r_d [c+1];
    logic [c:0]      r_v;

    always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
        for (int k = 0; k <= c; k++) r_d[k] <= '0;
        r_v <= '0;
      end else if (i_clear) begin
        for (int k = 0; k <= c; k++) r_d[k] <= '0;
        r_v <= '0;
      end else if (i_advance) begin
        r_d[0] <= w_in_d[c];
        r_v[0] <= w_in_v;
        for (int k = 1; k <= c; k++) begin
          r_d[k] <= r_d[k-1];
          r_v[k] <= r_v[k-1];
        end
      end
    end

    assign o_wei_data[c*IB_W +: IB_W] = r_d[c];
    assign o_col_valid[c]             = r_v[c];

`ifdef WEI_FEEDER_ZERO_DET_EN
    logic [IB_W-1:0] w_pre_d;
    logic            w_pre_v;
    logic            r_z;
    if (c == 0) begin : g_first
      assign w_pre_d = w_in_d[0];
      assign w_pre_v = w_in_v;
    end else begin : g_rest
      assign w_pre_d = r_d[c-1];
      assign w_pre_v = r_v[c-1];
    end

    // Flag computed from what enters the last stage so it lines up with o_wei_data.
    always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn)        r_z <= 1'b0;
      else if (i_clear)   r_z <= 1'b0;
      else if (i_advance) r_z <= (w_pre_d == '0) && w_pre_v;
    end
    assign o_zero[c] = r_z;
`endif
  end
endmodule

// File: tb/tb_wei_skew_feeder.sv
// Directed bench for wei_skew_feeder at X=4, IB_W=8, DEPTH=4.
module tb_wei_skew_feeder;
  localparam int X = 4, IB_W = 8, DEPTH = 4;

  logic            clk = 1'b0;
  logic            rstn, clear, sv, adv;
  logic [31:0]     sdata;
  logic            ready, empty, full;
  logic [31:0]     wdata;
  logic [3:0]      cvld;
  logic [2:0]      cnt;
`ifdef WEI_FEEDER_ZERO_DET_EN
  logic [3:0]      zero;
`endif

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  wei_skew_feeder #(.X(X), .IB_W(IB_W), .DEPTH(DEPTH)) dut (
    .i_clk        (clk),
    .i_rstn       (rstn),
    .i_clear      (clear),
    .i_sram_data  (sdata),
    .i_sram_valid (sv),
    .o_sram_ready (ready),
    .i_advance    (adv),
    .o_wei_data   (wdata),
    .o_col_valid  (cvld),
`ifdef WEI_FEEDER_ZERO_DET_EN
    .o_zero       (zero),
`endif
    .o_count      (cnt),
    .o_empty      (empty),
    .o_full       (full)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic [31:0] d, input logic [3:0] v);
    chk({tag, "_data"}, wdata, d);
    chk({tag, "_vld"}, {28'd0, cvld}, {28'd0, v});
  endtask

  function automatic logic [31:0] rowk(input int k);
    logic [7:0] b;
    b = 8'(16 * k);
    return {b + 8'd3, b + 8'd2, b + 8'd1, b};
  endfunction

  initial begin
    rstn = 1'b0; clear = 1'b0; sv = 1'b0; adv = 1'b0; sdata = '0;
    #1;
    chk("rst_count", {29'd0, cnt}, 32'd0);
    chk("rst_empty", {31'd0, empty}, 32'd1);
    chk("rst_full",  {31'd0, full}, 32'd0);
    chk("rst_ready", {31'd0, ready}, 32'd1);
    chk_out("rst", 32'h0, 4'h0);
    tick(); tick();
    rstn = 1'b1;
    tick();

    // single row, skew across columns
    sv = 1'b1; sdata = 32'h04030201;
    tick();
    chk("one_cnt", {29'd0, cnt}, 32'd1);
    sv = 1'b0; adv = 1'b1;
    tick(); chk_out("one_e1", 32'h00000001, 4'b0001);
    chk("one_cnt0", {29'd0, cnt}, 32'd0);
    tick(); chk_out("one_e2", 32'h00000200, 4'b0010);
    tick(); chk_out("one_e3", 32'h00030000, 4'b0100);
    tick(); chk_out("one_e4", 32'h04000000, 4'b1000);
    tick(); chk_out("one_e5", 32'h00000000, 4'b0000);

    // fill to full with advance low, fifth row held by source
    adv = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      sv = 1'b1; sdata = rowk(k);
      tick();
    end
    chk("full_cnt", {29'd0, cnt}, 32'd4);
    chk("full_full", {31'd0, full}, 32'd1);
    chk("full_rdy", {31'd0, ready}, 32'd0);
    sdata = rowk(5);
    tick();
    chk("full_hold", {29'd0, cnt}, 32'd4);
    adv = 1'b1;
    tick();
    chk("full_popref", {29'd0, cnt}, 32'd3);
    chk("full_c0_r1", {24'd0, wdata[7:0]}, {24'd0, rowk(1)[7:0]});
    tick();
    chk("full_pushpop", {29'd0, cnt}, 32'd3);
    chk("full_c0_r2", {24'd0, wdata[7:0]}, {24'd0, rowk(2)[7:0]});
    sv = 1'b0;
    tick(); chk("full_c0_r3", {24'd0, wdata[7:0]}, {24'd0, rowk(3)[7:0]});
    tick(); chk("full_c0_r4", {24'd0, wdata[7:0]}, {24'd0, rowk(4)[7:0]});
    chk("full_c3_r1", {24'd0, wdata[31:24]}, {24'd0, rowk(1)[31:24]});
    tick(); chk("full_c0_r5", {24'd0, wdata[7:0]}, {24'd0, rowk(5)[7:0]});
    chk("full_drain", {29'd0, cnt}, 32'd0);
    for (int i = 0; i < 4; i++) tick();
    chk_out("full_idle", 32'h0, 4'h0);

    // advance on empty with same-cycle push: bubble first
    adv = 1'b1; sv = 1'b1; sdata = 32'hA4A3A2A1;
    tick();
    chk_out("bub_e1", 32'h0, 4'b0000);
    chk("bub_cnt", {29'd0, cnt}, 32'd1);
    sv = 1'b0;
    tick();
    chk_out("bub_e2", 32'h000000A1, 4'b0001);
    for (int i = 0; i < 4; i++) tick();

    // stall mid-stream for 3 cycles
    adv = 1'b0; sv = 1'b1; sdata = 32'h34333231;
    tick();
    sdata = 32'h44434241;
    tick();
    sv = 1'b0; adv = 1'b1;
    tick(); chk_out("stl_e1", 32'h00000031, 4'b0001);
    tick(); chk_out("stl_e2", 32'h00003241, 4'b0011);
    adv = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick(); chk_out("stl_hold", 32'h00003241, 4'b0011);
    end
    adv = 1'b1;
    tick(); chk_out("stl_r1", 32'h00334200, 4'b0110);
    tick(); chk_out("stl_r2", 32'h34430000, 4'b1100);
    tick(); chk_out("stl_r3", 32'h44000000, 4'b1000);
    tick();

    // clear with rows queued and in flight
    adv = 1'b0; sv = 1'b1;
    sdata = rowk(1); tick();
    sdata = rowk(2); tick();
    adv = 1'b1;
    sdata = rowk(3); tick();
    sdata = rowk(4); tick();
    adv = 1'b0;
    sdata = rowk(5); tick();
    chk("clr_pre_cnt", {29'd0, cnt}, 32'd3);
    chk("clr_pre_vld", {28'd0, cvld}, 32'h3);
    clear = 1'b1; adv = 1'b1; sdata = rowk(6);
    tick();
    chk("clr_cnt", {29'd0, cnt}, 32'd0);
    chk("clr_empty", {31'd0, empty}, 32'd1);
    chk_out("clr", 32'h0, 4'h0);
    clear = 1'b0; sv = 1'b0;
    tick();
    chk_out("clr_after", 32'h0, 4'h0);
    chk("clr_cnt2", {29'd0, cnt}, 32'd0);

    // async reset pulse between edges
    adv = 1'b0; sv = 1'b1; sdata = 32'h11223344;
    tick(); tick();
    sv = 1'b0; adv = 1'b1;
    tick();
    chk_out("ar_pre", 32'h00000044, 4'b0001);
    #2 rstn = 1'b0;
    #1;
    chk_out("ar", 32'h0, 4'h0);
    chk("ar_cnt", {29'd0, cnt}, 32'd0);
    chk("ar_rdy", {31'd0, ready}, 32'd1);
    tick();
    rstn = 1'b1;
    tick();
    chk_out("ar_after", 32'h0, 4'h0);

`ifdef WEI_FEEDER_ZERO_DET_EN
    adv = 1'b0; sv = 1'b1; sdata = 32'h00050000;
    tick();
    sv = 1'b0; adv = 1'b1;
    tick(); chk("zd_e1", {28'd0, zero}, 32'b0001);
    tick(); chk("zd_e2", {28'd0, zero}, 32'b0010);
    tick(); chk("zd_e3", {28'd0, zero}, 32'b0000);
    tick(); chk("zd_e4", {28'd0, zero}, 32'b1000);
    tick(); chk("zd_e5", {28'd0, zero}, 32'b0000);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
